hacd_axi4_sram_slv: RTL and testbench
=====================================

# hacd_axi4_sram_slv

Parametrised, synthesizable AXI4 slave memory for the HACD memory-controller path. It is the drop-in successor to the single-transaction behavioural memory model. It supports configurable data width and depth, full per-byte write strobes, INCR bursts of any length, concurrent independent read and write channels, and up to BQ_DEPTH outstanding write responses. It sits on the MC side of the Hawk AXI4 buses in both simulation and FPGA builds.

## Interface
- DATA_W, 256: data width in bits; power of 2, at least 32.
- ADDR_W, 64: AXI address width.
- ID_W, 6: AXI ID width.
- DEPTH, 1024: memory words of DATA_W bits; power of 2.
- BQ_DEPTH, 4: write-response queue entries; power of 2, at least 2.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- awvalid/awready  in/out  1  AW handshake.
- awid  in  ID_W; awaddr  in  ADDR_W; awlen  in  8.
- wvalid/wready  in/out  1; wdata  in  DATA_W; wstrb  in  DATA_W/8; wlast  in  1.
- bvalid/bready  out/in  1; bid  out  ID_W; bresp  out  2.
- arvalid/arready  in/out  1; arid  in  ID_W; araddr  in  ADDR_W; arlen  in  8.
- rvalid/rready  out/in  1; rid  out  ID_W; rdata  out  DATA_W; rresp  out  2; rlast  out  1.

## Operation
- Word index is awaddr/araddr[ADDR_W-1:log2(DATA_W/8)]. Beat i targets index+i, taken modulo DEPTH. Burst type and size are ignored: every transfer is INCR at full width.
- Write FSM has two states, W_IDLE and W_DATA.
  - W_IDLE: awready = !bq_full. On the AW handshake, capture id, index and len, clear the beat count, and go to W_DATA.
  - W_DATA: wready = 1. Each wvalid&wready writes the bytes whose wstrb bits are set; other bytes keep their old value. The beat count then increments.
  - On the beat where count == len, push {id, resp} to the B queue and return to W_IDLE.
  - resp is SLVERR (2'b10) if wlast was wrong on any beat: missing on the final beat, or asserted early. Otherwise resp is OKAY.
  - W beats presented in W_IDLE are not accepted (wready = 0).
- B queue: a FIFO of {id, resp}. bvalid = !empty; bid/bresp come from the head entry. The head is popped on bvalid&bready. A push and a pop in the same cycle are both performed.
- Read FSM has two states, R_IDLE and R_DATA.
  - R_IDLE: arready = 1. On the AR handshake, load rdata <= mem[index], rid <= arid, rresp <= OKAY, rvalid <= 1, rlast <= (arlen == 0), and go to R_DATA.
  - R_DATA: on rvalid&rready for a non-last beat, load the next word into rdata and set rlast when the new beat is the final one. On the last beat, set rvalid <= 0 and rlast <= 0, and return to R_IDLE.
  - rvalid/rdata/rlast hold stable while rready = 0.
- Read and write run fully concurrently. If a read-word load and a write to the same word fall on the same edge, the read returns the old data (read-first).

## Timing
- Reset values: awready 0, wready 0, bvalid 0, bid 0, bresp 0, arready 0, rvalid 0, rid 0, rdata 0, rresp 0, rlast 0. Both FSMs reset to IDLE, the B queue resets empty, and memory contents are not reset.
- awready and arready rise in the first cycle after rst_n deasserts.
- AR handshake at edge k: first rvalid is visible after edge k. Subsequent beats follow back-to-back while rready = 1, so an N-beat burst takes N cycles. arready returns the cycle after rlast is accepted.
- AW handshake at edge k: wready is visible after edge k. The last W beat at edge m pushes the B queue, and bvalid is visible after edge m. awready is 1 again after edge m, unless the queue is full.
- Reset asserted mid-burst: all outputs return to their reset values immediately, and queued responses are lost.
- With the B queue full and bready = 0, awready stays 0 indefinitely. It rises the cycle after a pop.

## Configuration
- HACD_AXI_MEM_DECERR_EN defined: a burst whose start index ≥ DEPTH is handled as follows.
  - Writes: data is accepted and discarded, and bresp = DECERR (2'b11).
  - Reads: rdata = 0 and rresp = DECERR on every beat.
  - Beats of an in-range burst that cross DEPTH still wrap.
- Not defined: the index is truncated modulo DEPTH, and every response is OKAY except the wlast-mismatch SLVERR.

## Structure
- hacd_pkg gains AXI_RESP_OKAY / AXI_RESP_SLVERR / AXI_RESP_DECERR localparams and a wr_state_e / rd_state_e enum pair.
- One sub-module, hacd_axi_bq_fifo: a parametrised synchronous FIFO (width ID_W+2, depth BQ_DEPTH) with full/empty outputs.
- The memory array is inferred inline as DEPTH × DATA_W with per-byte write enables.

## Test plan
- Write 2 beats to 0x40 (awlen = 1, wstrb all ones, data A/B), then read it back (arlen = 1) -> rdata A then B, rlast on the 2nd beat, bresp OKAY, bid = awid.
- Write full word 0xFF…FF, then write 0x00…00 with wstrb = 0x0000FFFF, then read -> upper 128 bits 1s, lower 128 bits 0s.
- With bready = 0, issue 5 single-beat writes (BQ_DEPTH = 4) -> awready = 0 after the 4th; raising bready returns bids in issue order, and the 5th write then completes.
- 4-beat read with rready toggling 1,0,1,0… -> each beat holds stable while stalled, and the burst takes 8 cycles.
- Write with wlast on beat 0 of awlen = 1 -> bresp = SLVERR.
- With HACD_AXI_MEM_DECERR_EN defined and DEPTH = 1024, read word index 2048 -> rresp = 3, rdata = 0. Without the macro -> data of index 0, rresp = 0.

Source files
------------

// File: rtl/hacd_pkg.sv
// Shared HACD memory-controller definitions: AXI response codes and the
// channel FSM state types used by the AXI4 SRAM slave.
package hacd_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_DATA = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/hacd_axi_bq_fifo.sv
// Write-response queue: small synchronous FIFO with full/empty flags.
// A push and a pop in the same cycle are both performed, including when full.
module hacd_axi_bq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] store [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = store[rd_ptr[PW-1:0]];

    // Pointer update; contents are not reset, only the pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/hacd_axi4_sram_slv.sv
// AXI4 slave SRAM for the HACD memory-controller path. Independent read and
// write channels, INCR bursts at full width with index wrap modulo DEPTH,
// per-byte strobes, and a BQ_DEPTH-entry write-response queue.
// Optional feature macro: HACD_AXI_MEM_DECERR_EN (out-of-range start index
// answers DECERR instead of aliasing).
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for AW; awready while the B queue has room
//   W_DATA | accepting W beats of the captured burst
// Read FSM
//   state  | meaning
//   R_IDLE | waiting for AR; arready high
//   R_DATA | presenting R beats until rlast is accepted
module hacd_axi4_sram_slv #(
    parameter int DATA_W   = 256,
    parameter int ADDR_W   = 64,
    parameter int ID_W     = 6,
    parameter int DEPTH    = 1024,
    parameter int BQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    output logic                rvalid,
    input  logic                rready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast
);

    import hacd_pkg::*;

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int BQ_W   = ID_W + 2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              alive;
    logic              aw_oob;
    logic              ar_oob;
    logic              unused_addr;

    wr_state_e         w_state;
    wr_state_e         w_state_nxt;
    logic [ID_W-1:0]   w_id;
    logic [IDX_W-1:0]  w_idx;
    logic [7:0]        w_len;
    logic [7:0]        w_cnt;
    logic              w_err;
    logic              w_dec;
    logic              aw_hs;
    logic              w_hs;
    logic              w_last_beat;
    logic              w_err_now;
    logic [1:0]        w_resp;
    logic [IDX_W-1:0]  w_addr;

    logic              bq_full;
    logic              bq_empty;
    logic              bq_pop;
    logic [BQ_W-1:0]   bq_dout;

    rd_state_e         r_state;
    rd_state_e         r_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic [7:0]        r_cnt_nxt;
    logic [IDX_W-1:0]  r_addr_nxt;
    logic              r_dec;
    logic              ar_hs;

`ifdef HACD_AXI_MEM_DECERR_EN
    assign aw_oob      = |awaddr[ADDR_W-1:OFF+IDX_W];
    assign ar_oob      = |araddr[ADDR_W-1:OFF+IDX_W];
    assign unused_addr = ^{awaddr[OFF-1:0], araddr[OFF-1:0]};
`else
    assign aw_oob      = 1'b0;
    assign ar_oob      = 1'b0;
    assign unused_addr = ^{awaddr[ADDR_W-1:OFF+IDX_W], awaddr[OFF-1:0],
                           araddr[ADDR_W-1:OFF+IDX_W], araddr[OFF-1:0]};
`endif

    // Holds both address channels off until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    // ---------------- write channel ----------------

    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign w_last_beat = (w_cnt == w_len);
    assign w_err_now   = w_err || (wlast != w_last_beat);
    assign w_resp      = w_dec     ? AXI_RESP_DECERR :
                         w_err_now ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign w_addr      = w_idx + IDX_W'(w_cnt);

    // Write FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_state_nxt;
    end

    // Write FSM next state and channel ready outputs.
    always_comb begin
        w_state_nxt = w_state;
        awready     = 1'b0;
        wready      = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = alive && !bq_full;
                if (awvalid && awready) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_last_beat) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Burst context capture and beat tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_id  <= '0;
            w_idx <= '0;
            w_len <= '0;
            w_cnt <= '0;
            w_err <= 1'b0;
            w_dec <= 1'b0;
        end else if (aw_hs) begin
            w_id  <= awid;
            w_idx <= awaddr[OFF +: IDX_W];
            w_len <= awlen;
            w_cnt <= '0;
            w_err <= 1'b0;
            w_dec <= aw_oob;
        end else if (w_hs) begin
            w_cnt <= w_cnt + 8'd1;
            w_err <= w_err_now;
        end
    end

    // Byte-masked memory write; out-of-range bursts are swallowed.
    always_ff @(posedge clk) begin
        if (w_hs && !w_dec) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[w_addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // An AW is only taken with room in the queue and only one burst is in
    // flight, so the final-beat push always finds a free slot.
    hacd_axi_bq_fifo #(
        .W     (BQ_W),
        .DEPTH (BQ_DEPTH)
    ) u_bq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_hs && w_last_beat),
        .din   ({w_id, w_resp}),
        .pop   (bq_pop),
        .dout  (bq_dout),
        .full  (bq_full),
        .empty (bq_empty)
    );

    assign bvalid        = !bq_empty;
    assign bq_pop        = bvalid && bready;
    assign {bid, bresp}  = bq_empty ? '0 : bq_dout;

    // ---------------- read channel ----------------

    assign ar_hs      = arvalid && arready;
    assign r_cnt_nxt  = r_cnt + 8'd1;
    assign r_addr_nxt = r_idx + IDX_W'(r_cnt_nxt);

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_state_nxt;
    end

    // Read FSM next state and arready.
    always_comb begin
        r_state_nxt = r_state;
        arready     = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = alive;
                if (arvalid && arready) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                if (rvalid && rready && rlast) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // R beat generation; the memory read is registered so a same-edge
    // write to the word is seen only by later loads (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rid    <= '0;
            rdata  <= '0;
            rresp  <= AXI_RESP_OKAY;
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            r_idx  <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_dec  <= 1'b0;
        end else if (ar_hs) begin
            rid    <= arid;
            rdata  <= ar_oob ? '0 : mem[araddr[OFF +: IDX_W]];
            rresp  <= ar_oob ? AXI_RESP_DECERR : AXI_RESP_OKAY;
            rvalid <= 1'b1;
            rlast  <= (arlen == 8'd0);
            r_idx  <= araddr[OFF +: IDX_W];
            r_len  <= arlen;
            r_cnt  <= '0;
            r_dec  <= ar_oob;
        end else if (rvalid && rready) begin
            if (rlast) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
            end else begin
                r_cnt <= r_cnt_nxt;
                rdata <= r_dec ? '0 : mem[r_addr_nxt];
                rlast <= (r_cnt_nxt == r_len);
            end
        end
    end

endmodule

// File: tb/tb_hacd_axi4_sram_slv.sv
// Self-checking bench for hacd_axi4_sram_slv: directed scenarios plus
// randomized bursts checked against a word-array model of the memory and a
// queue of expected write responses.
module tb_hacd_axi4_sram_slv;

    localparam int DW  = 256;
    localparam int AW  = 64;
    localparam int IW  = 6;
    localparam int DEP = 1024;
    localparam int BQ  = 4;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            awvalid, awready;
    logic [IW-1:0]   awid;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic            wvalid, wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            bvalid, bready;
    logic [IW-1:0]   bid;
    logic [1:0]      bresp;
    logic            arvalid, arready;
    logic [IW-1:0]   arid;
    logic [AW-1:0]   araddr;
    logic [7:0]      arlen;
    logic            rvalid, rready;
    logic [IW-1:0]   rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [DEP];
    b_t            exp_b [$];

    hacd_axi4_sram_slv #(
        .DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .DEPTH(DEP), .BQ_DEPTH(BQ)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tmo(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_awready"}, DW'(awready), DW'(0));
        chk({tag, "_wready"},  DW'(wready),  DW'(0));
        chk({tag, "_bvalid"},  DW'(bvalid),  DW'(0));
        chk({tag, "_bid"},     DW'(bid),     DW'(0));
        chk({tag, "_bresp"},   DW'(bresp),   DW'(0));
        chk({tag, "_arready"}, DW'(arready), DW'(0));
        chk({tag, "_rvalid"},  DW'(rvalid),  DW'(0));
        chk({tag, "_rid"},     DW'(rid),     DW'(0));
        chk({tag, "_rdata"},   rdata,        DW'(0));
        chk({tag, "_rresp"},   DW'(rresp),   DW'(0));
        chk({tag, "_rlast"},   DW'(rlast),   DW'(0));
    endtask

    function automatic bit out_of_range(input int widx);
`ifdef HACD_AXI_MEM_DECERR_EN
        return widx >= DEP;
`else
        return (widx < 0);
`endif
    endfunction

    // dmode: 0 random, 1 all ones, 2 all zeros; smode: 0 all ones, 1 random, 2 low 16 bytes.
    // bad_beat: beat whose wlast is inverted (-1 for none).
    task automatic do_write(input logic [IW-1:0] id, input int widx, input logic [7:0] len,
                            input int dmode, input int smode, input int bad_beat);
        logic [DW-1:0]   d;
        logic [DW/8-1:0] s;
        int              n;
        bit              dec;
        bit              lerr;
        b_t              e;
        dec = out_of_range(widx);
        @(negedge clk);
        awvalid = 1'b1;
        awid    = id;
        awaddr  = (AW'(widx) << 5) | AW'($urandom_range(0, 31));
        awlen   = len;
        n = 0;
        while (awready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            tmo("aw_wait");
            awvalid = 1'b0;
            return;
        end
        @(negedge clk);
        awvalid = 1'b0;
        lerr = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom;
            if (dmode == 1) d = '1;
            if (dmode == 2) d = '0;
            s = (smode == 1) ? DW/8'($urandom) : (smode == 2) ? DW/8'(32'h0000_FFFF) : '1;
            wvalid = 1'b1;
            wdata  = d;
            wstrb  = s;
            wlast  = (i == int'(len)) ^ (i == bad_beat);
            if (i == bad_beat) lerr = 1'b1;
            n = 0;
            while (wready !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) begin
                tmo("w_wait");
                wvalid = 1'b0;
                return;
            end
            if (!dec) begin
                for (int b = 0; b < DW / 8; b++)
                    if (s[b]) ref_mem[(widx + i) % DEP][b*8 +: 8] = d[b*8 +: 8];
            end
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        e.id   = id;
        e.resp = dec ? 2'b11 : lerr ? 2'b10 : 2'b00;
        exp_b.push_back(e);
        chk("bvalid_after_last", DW'(bvalid), DW'(1));
        chk("awready_after_last", DW'(awready), DW'(exp_b.size() < BQ));
    endtask

    task automatic collect_b(input int cnt);
        b_t e;
        int n;
        for (int k = 0; k < cnt; k++) begin
            bready = 1'b1;
            n = 0;
            while (bvalid !== 1'b1 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 2000 || exp_b.size() == 0) begin
                tmo("b_wait");
            end else begin
                e = exp_b.pop_front();
                chk("bid", DW'(bid), DW'(e.id));
                chk("bresp", DW'(bresp), DW'(e.resp));
            end
            @(negedge clk);
        end
        bready = 1'b0;
    endtask

    // mode: 0 rready always 1, 1 toggling starting at 1, 2 random.
    // cycles: edges after the AR handshake up to and including the last accept.
    task automatic do_read(input logic [IW-1:0] id, input int widx, input logic [7:0] len,
                           input int mode, output int cycles);
        logic [DW-1:0] exp_d;
        int            n;
        int            beat;
        bit            dec;
        bit            tog;
        dec    = out_of_range(widx);
        cycles = 0;
        @(negedge clk);
        arvalid = 1'b1;
        arid    = id;
        araddr  = (AW'(widx) << 5) | AW'($urandom_range(0, 31));
        arlen   = len;
        n = 0;
        while (arready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            tmo("ar_wait");
            arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        arvalid = 1'b0;
        beat = 0;
        tog  = 1'b1;
        while (beat <= int'(len) && cycles < 4000) begin
            exp_d = dec ? '0 : ref_mem[(widx + beat) % DEP];
            chk("rvalid", DW'(rvalid), DW'(1));
            chk("rdata", rdata, exp_d);
            chk("rid", DW'(rid), DW'(id));
            chk("rresp", DW'(rresp), dec ? DW'(3) : DW'(0));
            chk("rlast", DW'(rlast), DW'(beat == int'(len)));
            rready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = !tog;
            @(negedge clk);
            cycles++;
            if (rready) beat++;
        end
        rready = 1'b0;
        if (beat <= int'(len)) tmo("r_burst");
        chk("rvalid_after_burst", DW'(rvalid), DW'(0));
        chk("rlast_after_burst", DW'(rlast), DW'(0));
        chk("arready_after_burst", DW'(arready), DW'(1));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int widx;
        int len;
        rst_n   = 1'b0;
        awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0;
        wvalid  = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        bready  = 1'b0;
        arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0;
        rready  = 1'b0;

        // Reset values, then both address channels ready one edge after release.
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("awready_post_reset", DW'(awready), DW'(1));
        chk("arready_post_reset", DW'(arready), DW'(1));

        // Fill the whole memory so every later read has a defined expectation.
        for (int k = 0; k < 4; k++) begin
            do_write(IW'(k), k * 256, 8'd255, 0, 0, -1);
            collect_b(1);
        end

        // Two-beat write at 0x40 then read back.
        do_write(6'h2A, 2, 8'd1, 0, 0, -1);
        collect_b(1);
        do_read(6'h15, 2, 8'd1, 0, cyc);
        chk("b2b_cycles_2", DW'(cyc), DW'(2));

        // Full ones, then zeros under a low-16-byte strobe: upper half stays ones.
        do_write(6'h01, 50, 8'd0, 1, 0, -1);
        collect_b(1);
        do_write(6'h02, 50, 8'd0, 2, 2, -1);
        collect_b(1);
        do_read(6'h03, 50, 8'd0, 0, cyc);

        // Response queue fill: four writes with bready low block the fifth AW.
        for (int k = 1; k <= 4; k++) do_write(IW'(k), 10 + k, 8'd0, 0, 0, -1);
        repeat (3) @(negedge clk);
        chk("awready_bq_full", DW'(awready), DW'(0));
        collect_b(1);
        chk("awready_after_pop", DW'(awready), DW'(1));
        collect_b(3);
        do_write(6'd5, 15, 8'd0, 0, 0, -1);
        collect_b(1);

        // Four-beat read with rready toggling: 8 cycles counting the AR edge.
        do_read(6'h07, 2, 8'd3, 1, cyc);
        chk("toggle_cycles", DW'(cyc + 1), DW'(8));
        do_read(6'h08, 100, 8'd3, 0, cyc);
        chk("b2b_cycles_4", DW'(cyc), DW'(4));

        // wlast errors: early on beat 0, and missing on the final beat.
        do_write(6'h09, 200, 8'd1, 0, 0, 0);
        collect_b(1);
        do_write(6'h0A, 210, 8'd0, 0, 0, 0);
        collect_b(1);
        do_read(6'h0B, 200, 8'd1, 0, cyc);

        // Index wrap across the top of memory.
        do_write(6'h0C, 1022, 8'd3, 0, 1, -1);
        collect_b(1);
        do_read(6'h0D, 1020, 8'd7, 2, cyc);

        // Start index beyond DEPTH: DECERR with the macro, aliasing without.
        do_read(6'h0E, 2048, 8'd0, 0, cyc);
        do_write(6'h0F, 2048, 8'd1, 0, 0, -1);
        collect_b(1);
        do_read(6'h10, 0, 8'd1, 0, cyc);

        // Concurrent write and read on disjoint regions.
        fork
            do_write(6'h11, 300, 8'd7, 0, 1, -1);
            begin
                int c2;
                do_read(6'h12, 600, 8'd7, 0, c2);
            end
        join
        collect_b(1);
        do_read(6'h13, 300, 8'd7, 2, cyc);

        // Randomized bursts.
        for (int it = 0; it < 16; it++) begin
            widx = $urandom_range(0, DEP - 1);
            len  = $urandom_range(0, 15);
            do_write(IW'($urandom), widx, 8'(len), 0, 1, -1);
            collect_b(1);
            do_read(IW'($urandom), widx, 8'(len), 2, cyc);
        end

        // Reset in the middle of a read burst with a response queued.
        do_write(6'h20, 30, 8'd0, 0, 0, -1);
        @(negedge clk);
        arvalid = 1'b1; arid = 6'h21; araddr = AW'(40) << 5; arlen = 8'd5;
        @(negedge clk);
        arvalid = 1'b0;
        chk("rvalid_mid_burst", DW'(rvalid), DW'(1));
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("midreset");
        exp_b.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("awready_after_midreset", DW'(awready), DW'(1));
        chk("arready_after_midreset", DW'(arready), DW'(1));
        chk("bvalid_after_midreset", DW'(bvalid), DW'(0));
        do_read(6'h22, 30, 8'd0, 0, cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
